// File: rtl/ipcs_mc_fifo.sv
// Multi-channel FIFO: CH logical queues carved out of one CH*DEPTH x WIDTH dual-port RAM.
// Optional high-water-mark tracking is enabled by defining IPCS_MC_FIFO_HWM_EN.
module ipcs_mc_fifo #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 128,
    parameter int PTR       = 7,
    parameter int CH        = 4,
    parameter int CHW       = 2,
    parameter int AF_THRESH = 120
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wren,
    input  logic [CHW-1:0]        wrch,
    input  logic [WIDTH-1:0]      datain,
    input  logic                  rden,
    input  logic [CHW-1:0]        rdch,
    output logic [WIDTH-1:0]      dataout,
    output logic                  rdvalid,
    output logic [CHW-1:0]        rdvalid_ch,
    output logic [CH-1:0]         full,
    output logic [CH-1:0]         empty,
    output logic [CH-1:0]         almost_full,
    output logic [CH*(PTR+1)-1:0] usedw,
    output logic [CH-1:0]         ovf,
    output logic [CH-1:0]         udf,
    input  logic                  err_clr,
    output logic [CH*(PTR+1)-1:0] hwm,
    input  logic                  hwm_clr
);
    localparam int UW = PTR + 1;
    localparam int AW = CHW + PTR;
    localparam logic [CHW:0] CH_L    = (CHW + 1)'(CH);
    localparam logic [PTR:0] DEPTH_L = UW'(DEPTH);
    localparam logic [PTR:0] AF_L    = UW'(AF_THRESH);

    if (DEPTH != 2 ** PTR) begin : g_depth_chk
        $error("ipcs_mc_fifo: DEPTH must equal 2**PTR");
    end
    if (CH < 1 || CH > 16 || (2 ** CHW) < CH) begin : g_ch_chk
        $error("ipcs_mc_fifo: CH must be 1..16 and fit in CHW bits");
    end

    logic                     wr_ch_ok;
    logic                     rd_ch_ok;
    logic [CH-1:0]            wr_hit;
    logic [CH-1:0]            rd_hit;
    logic                     wr_any;
    logic                     rd_any;
    logic [CH-1:0][PTR-1:0]   wr_ptr_all;
    logic [CH-1:0][PTR-1:0]   rd_ptr_all;
    logic [AW-1:0]            waddr;
    logic [AW-1:0]            raddr;

    assign wr_ch_ok = ({1'b0, wrch} < CH_L);
    assign rd_ch_ok = ({1'b0, rdch} < CH_L);
    assign wr_any   = |wr_hit;
    assign rd_any   = |rd_hit;
    assign waddr    = {wrch, wr_ptr_all[wrch]};
    assign raddr    = {rdch, rd_ptr_all[rdch]};

    // Shared storage; contents intentionally not reset.
    logic [WIDTH-1:0] mem [CH*DEPTH];

    always_ff @(posedge clk) begin
        if (wr_any) begin
            mem[waddr] <= datain;
        end
    end

    // Registered read port; output holds between accepted reads.
    logic [WIDTH-1:0] dataout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            dataout_q <= '0;
        end else if (rd_any) begin
            dataout_q <= mem[raddr];
        end
    end

    logic           rdvalid_q;
    logic           rdvalid_d;
    logic [CHW-1:0] rdvalid_ch_q;
    logic [CHW-1:0] rdvalid_ch_d;

    always_comb begin
        rdvalid_d    = rd_any;
        rdvalid_ch_d = rdvalid_ch_q;
        if (rd_any) begin
            rdvalid_ch_d = rdch;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdvalid_q    <= 1'b0;
            rdvalid_ch_q <= '0;
        end else begin
            rdvalid_q    <= rdvalid_d;
            rdvalid_ch_q <= rdvalid_ch_d;
        end
    end

    assign dataout    = dataout_q;
    assign rdvalid    = rdvalid_q;
    assign rdvalid_ch = rdvalid_ch_q;

    genvar gi;
    for (gi = 0; gi < CH; gi++) begin : g_ch
        logic [PTR-1:0] wr_ptr_q, wr_ptr_d;
        logic [PTR-1:0] rd_ptr_q, rd_ptr_d;
        logic [PTR:0]   usedw_q, usedw_d;
        logic           full_q, full_d;
        logic           empty_q, empty_d;
        logic           af_q, af_d;
        logic           ovf_q, ovf_d;
        logic           udf_q, udf_d;
        logic           wr_sel;
        logic           rd_sel;

        assign wr_sel = wren && wr_ch_ok && (wrch == CHW'(gi));
        assign rd_sel = rden && rd_ch_ok && (rdch == CHW'(gi));
        // Acceptance looks only at registered flags: no same-cycle bypass.
        assign wr_hit[gi] = wr_sel && !full_q && !reset;
        assign rd_hit[gi] = rd_sel && !empty_q && !reset;

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            usedw_d  = usedw_q;
            if (wr_hit[gi]) begin
                wr_ptr_d = wr_ptr_q + PTR'(1);
            end
            if (rd_hit[gi]) begin
                rd_ptr_d = rd_ptr_q + PTR'(1);
            end
            if (wr_hit[gi] && !rd_hit[gi]) begin
                usedw_d = usedw_q + UW'(1);
            end else if (!wr_hit[gi] && rd_hit[gi]) begin
                usedw_d = usedw_q - UW'(1);
            end
            full_d  = (usedw_d == DEPTH_L);
            empty_d = (usedw_d == '0);
            af_d    = (usedw_d >= AF_L);
            // A new error event outranks a simultaneous clear.
            ovf_d   = (ovf_q && !err_clr) || (wr_sel && full_q);
            udf_d   = (udf_q && !err_clr) || (rd_sel && empty_q);
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                usedw_q  <= '0;
                full_q   <= 1'b0;
                empty_q  <= 1'b1;
                af_q     <= 1'b0;
                ovf_q    <= 1'b0;
                udf_q    <= 1'b0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                usedw_q  <= usedw_d;
                full_q   <= full_d;
                empty_q  <= empty_d;
                af_q     <= af_d;
                ovf_q    <= ovf_d;
                udf_q    <= udf_d;
            end
        end

        assign wr_ptr_all[gi]          = wr_ptr_q;
        assign rd_ptr_all[gi]          = rd_ptr_q;
        assign usedw[gi*UW +: UW]      = usedw_q;
        assign full[gi]                = full_q;
        assign empty[gi]               = empty_q;
        assign almost_full[gi]         = af_q;
        assign ovf[gi]                 = ovf_q;
        assign udf[gi]                 = udf_q;

`ifdef IPCS_MC_FIFO_HWM_EN
        logic [PTR:0] hwm_q, hwm_d;

        always_comb begin
            hwm_d = hwm_q;
            if (hwm_clr || (usedw_d > hwm_q)) begin
                hwm_d = usedw_d;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                hwm_q <= '0;
            end else begin
                hwm_q <= hwm_d;
            end
        end

        assign hwm[gi*UW +: UW] = hwm_q;
`else
        assign hwm[gi*UW +: UW] = '0;
`endif
    end

`ifndef IPCS_MC_FIFO_HWM_EN
    logic unused_hwm_clr;
    assign unused_hwm_clr = hwm_clr;
`endif

endmodule

// File: tb/tb_ipcs_mc_fifo.sv
// Self-checking bench for ipcs_mc_fifo: vector table, directed corner sequences and a
// queue-based scoreboard checked every cycle.
module tb_ipcs_mc_fifo;
    localparam int WIDTH = 64;
    localparam int DEPTH = 128;
    localparam int PTR   = 7;
    localparam int CH    = 4;
    localparam int CHW   = 2;
    localparam int AF    = 120;
    localparam int UW    = PTR + 1;

    logic                clk = 1'b0;
    logic                reset;
    logic                wren;
    logic [CHW-1:0]      wrch;
    logic [WIDTH-1:0]    datain;
    logic                rden;
    logic [CHW-1:0]      rdch;
    logic [WIDTH-1:0]    dataout;
    logic                rdvalid;
    logic [CHW-1:0]      rdvalid_ch;
    logic [CH-1:0]       full;
    logic [CH-1:0]       empty;
    logic [CH-1:0]       almost_full;
    logic [CH*UW-1:0]    usedw;
    logic [CH-1:0]       ovf;
    logic [CH-1:0]       udf;
    logic                err_clr;
    logic [CH*UW-1:0]    hwm;
    logic                hwm_clr;

    always #5 clk = ~clk;

    ipcs_mc_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .PTR(PTR), .CH(CH), .CHW(CHW), .AF_THRESH(AF)
    ) dut (
        .clk(clk), .reset(reset), .wren(wren), .wrch(wrch), .datain(datain),
        .rden(rden), .rdch(rdch), .dataout(dataout), .rdvalid(rdvalid),
        .rdvalid_ch(rdvalid_ch), .full(full), .empty(empty), .almost_full(almost_full),
        .usedw(usedw), .ovf(ovf), .udf(udf), .err_clr(err_clr), .hwm(hwm), .hwm_clr(hwm_clr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // Behavioural reference model.
    typedef struct {
        logic [CHW-1:0]   ch;
        logic [WIDTH-1:0] d;
    } rd_t;

    logic [WIDTH-1:0] m_q [CH][$];
    int               m_used [CH];
    logic             m_ovf [CH];
    logic             m_udf [CH];
    int               m_hwm [CH];
    logic [WIDTH-1:0] m_dout;
    rd_t              exp_q [$];

    task automatic model_step();
        logic rd_ok;
        logic wr_ok;
        rd_t  r;
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                m_q[c].delete();
                m_used[c] = 0;
                m_ovf[c]  = 1'b0;
                m_udf[c]  = 1'b0;
                m_hwm[c]  = 0;
            end
            exp_q.delete();
            m_dout = '0;
            return;
        end
        rd_ok = rden && (int'(rdch) < CH) && (m_used[rdch] > 0);
        wr_ok = wren && (int'(wrch) < CH) && (m_used[wrch] < DEPTH);
        if (err_clr) begin
            for (int c = 0; c < CH; c++) begin
                m_ovf[c] = 1'b0;
                m_udf[c] = 1'b0;
            end
        end
        if (wren && (int'(wrch) < CH) && !wr_ok) m_ovf[wrch] = 1'b1;
        if (rden && (int'(rdch) < CH) && !rd_ok) m_udf[rdch] = 1'b1;
        if (rd_ok) begin
            r.ch = rdch;
            r.d  = m_q[rdch].pop_front();
            exp_q.push_back(r);
            m_used[rdch]--;
        end
        if (wr_ok) begin
            m_q[wrch].push_back(datain);
            m_used[wrch]++;
        end
`ifdef IPCS_MC_FIFO_HWM_EN
        for (int c = 0; c < CH; c++) begin
            if (hwm_clr || (m_used[c] > m_hwm[c])) m_hwm[c] = m_used[c];
        end
`endif
    endtask

    task automatic check_outputs();
        rd_t r;
        if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            check("rdvalid", 64'(rdvalid), 64'd1);
            check("rd_data", dataout, r.d);
            check("rd_ch", 64'(rdvalid_ch), 64'(r.ch));
            m_dout = r.d;
        end else begin
            check("rdvalid", 64'(rdvalid), 64'd0);
        end
        check("dataout", dataout, m_dout);
        for (int c = 0; c < CH; c++) begin
            check($sformatf("usedw[%0d]", c), 64'(usedw[c*UW +: UW]), 64'(m_used[c]));
            check($sformatf("full[%0d]", c), 64'(full[c]), 64'(m_used[c] == DEPTH));
            check($sformatf("empty[%0d]", c), 64'(empty[c]), 64'(m_used[c] == 0));
            check($sformatf("almost_full[%0d]", c), 64'(almost_full[c]), 64'(m_used[c] >= AF));
            check($sformatf("ovf[%0d]", c), 64'(ovf[c]), 64'(m_ovf[c]));
            check($sformatf("udf[%0d]", c), 64'(udf[c]), 64'(m_udf[c]));
            check($sformatf("hwm[%0d]", c), 64'(hwm[c*UW +: UW]), 64'(m_hwm[c]));
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic we, input logic [CHW-1:0] wc, input logic [WIDTH-1:0] d,
                         input logic re, input logic [CHW-1:0] rc);
        reset   = 1'b0;
        wren    = we;
        wrch    = wc;
        datain  = d;
        rden    = re;
        rdch    = rc;
        err_clr = 1'b0;
        hwm_clr = 1'b0;
    endtask

    task automatic do_reset();
        drive(1'b0, 2'd0, 64'd0, 1'b0, 2'd0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic             we;
        logic [CHW-1:0]   wc;
        logic [WIDTH-1:0] d;
        logic             re;
        logic [CHW-1:0]   rc;
        logic             ec;
        logic [31:0]      e_used;
        logic [3:0]       e_empty;
        logic             e_rv;
        logic [WIDTH-1:0] e_dout;
        logic [CHW-1:0]   e_rch;
        logic [3:0]       e_udf;
    } vec_t;

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{1'b1, 2'd1, 64'hA0, 1'b0, 2'd0, 1'b0, 32'h0000_0100, 4'b1101, 1'b0, 64'h00, 2'd0, 4'b0000};
        tbl[1]  = '{1'b1, 2'd1, 64'hA1, 1'b0, 2'd0, 1'b0, 32'h0000_0200, 4'b1101, 1'b0, 64'h00, 2'd0, 4'b0000};
        tbl[2]  = '{1'b1, 2'd1, 64'hA2, 1'b0, 2'd0, 1'b0, 32'h0000_0300, 4'b1101, 1'b0, 64'h00, 2'd0, 4'b0000};
        tbl[3]  = '{1'b0, 2'd0, 64'h00, 1'b1, 2'd1, 1'b0, 32'h0000_0200, 4'b1101, 1'b1, 64'hA0, 2'd1, 4'b0000};
        tbl[4]  = '{1'b0, 2'd0, 64'h00, 1'b1, 2'd1, 1'b0, 32'h0000_0100, 4'b1101, 1'b1, 64'hA1, 2'd1, 4'b0000};
        tbl[5]  = '{1'b0, 2'd0, 64'h00, 1'b1, 2'd1, 1'b0, 32'h0000_0000, 4'b1111, 1'b1, 64'hA2, 2'd1, 4'b0000};
        tbl[6]  = '{1'b0, 2'd0, 64'h00, 1'b0, 2'd0, 1'b0, 32'h0000_0000, 4'b1111, 1'b0, 64'hA2, 2'd0, 4'b0000};
        tbl[7]  = '{1'b0, 2'd0, 64'h00, 1'b1, 2'd1, 1'b0, 32'h0000_0000, 4'b1111, 1'b0, 64'hA2, 2'd0, 4'b0010};
        tbl[8]  = '{1'b0, 2'd0, 64'h00, 1'b0, 2'd0, 1'b1, 32'h0000_0000, 4'b1111, 1'b0, 64'hA2, 2'd0, 4'b0000};
        tbl[9]  = '{1'b1, 2'd0, 64'h55, 1'b1, 2'd0, 1'b0, 32'h0000_0001, 4'b1110, 1'b0, 64'hA2, 2'd0, 4'b0001};
        tbl[10] = '{1'b0, 2'd0, 64'h00, 1'b0, 2'd0, 1'b1, 32'h0000_0001, 4'b1110, 1'b0, 64'hA2, 2'd0, 4'b0000};
        tbl[11] = '{1'b0, 2'd0, 64'h00, 1'b1, 2'd0, 1'b0, 32'h0000_0000, 4'b1111, 1'b1, 64'h55, 2'd0, 4'b0000};

        do_reset();
        check("reset_usedw", 64'(usedw), 64'd0);
        check("reset_empty", 64'(empty), 64'hF);
        check("reset_dataout", dataout, 64'd0);
        check("reset_rdvalid_ch", 64'(rdvalid_ch), 64'd0);

        // Basic write/read on ch1, no-bypass underflow on ch0, err_clr.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].we, tbl[i].wc, tbl[i].d, tbl[i].re, tbl[i].rc);
            err_clr = tbl[i].ec;
            tick();
            check($sformatf("tbl%0d_usedw", i), 64'(usedw), 64'(tbl[i].e_used));
            check($sformatf("tbl%0d_empty", i), 64'(empty), 64'(tbl[i].e_empty));
            check($sformatf("tbl%0d_rdvalid", i), 64'(rdvalid), 64'(tbl[i].e_rv));
            check($sformatf("tbl%0d_dataout", i), dataout, tbl[i].e_dout);
            check($sformatf("tbl%0d_udf", i), 64'(udf), 64'(tbl[i].e_udf));
            if (tbl[i].e_rv) check($sformatf("tbl%0d_rdch", i), 64'(rdvalid_ch), 64'(tbl[i].e_rch));
        end

        // High-water mark: fill ch0 to 50, drain to 10, then clear.
        do_reset();
        for (int k = 0; k < 50; k++) begin
            drive(1'b1, 2'd0, 64'(32'h0500_0000 + k), 1'b0, 2'd0);
            tick();
        end
        for (int k = 0; k < 40; k++) begin
            drive(1'b0, 2'd0, 64'd0, 1'b1, 2'd0);
            tick();
        end
        drive(1'b0, 2'd0, 64'd0, 1'b0, 2'd0);
        tick();
`ifdef IPCS_MC_FIFO_HWM_EN
        check("hwm0_peak", 64'(hwm[UW-1:0]), 64'd50);
`else
        check("hwm0_off", 64'(hwm), 64'd0);
`endif
        hwm_clr = 1'b1;
        tick();
`ifdef IPCS_MC_FIFO_HWM_EN
        check("hwm0_clr", 64'(hwm[UW-1:0]), 64'd10);
`else
        check("hwm0_off_clr", 64'(hwm), 64'd0);
`endif
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 2'd0, 64'd0, 1'b1, 2'd0);
            tick();
        end

        // Fill ch2 to full, almost_full boundary, overflow, full+read same cycle.
        for (int k = 1; k <= DEPTH; k++) begin
            drive(1'b1, 2'd2, 64'(32'h2000_0000 + k), 1'b0, 2'd0);
            tick();
            if (k == AF - 1) check("af2_before", 64'(almost_full[2]), 64'd0);
            if (k == AF) check("af2_at", 64'(almost_full[2]), 64'd1);
        end
        check("full2", 64'(full[2]), 64'd1);
        check("usedw2_full", 64'(usedw[2*UW +: UW]), 64'd128);
        drive(1'b1, 2'd2, 64'hDEAD, 1'b0, 2'd0);
        tick();
        check("ovf2", 64'(ovf[2]), 64'd1);
        check("usedw2_ovf", 64'(usedw[2*UW +: UW]), 64'd128);
        drive(1'b1, 2'd2, 64'hBEEF, 1'b1, 2'd2);
        tick();
        check("usedw2_nobypass", 64'(usedw[2*UW +: UW]), 64'd127);
        for (int k = 0; k < DEPTH - 1; k++) begin
            drive(1'b0, 2'd0, 64'd0, 1'b1, 2'd2);
            err_clr = (k == 0);
            tick();
        end
        check("empty2_drained", 64'(empty[2]), 64'd1);

        // ch3 at 64 with streaming write+read across the pointer wrap.
        for (int k = 0; k < 64; k++) begin
            drive(1'b1, 2'd3, 64'(32'h3000_0000 + k), 1'b0, 2'd0);
            tick();
        end
        for (int k = 64; k < 164; k++) begin
            drive(1'b1, 2'd3, 64'(32'h3000_0000 + k), 1'b1, 2'd3);
            tick();
        end
        check("usedw3_steady", 64'(usedw[3*UW +: UW]), 64'd64);
        for (int k = 0; k < 64; k++) begin
            drive(1'b0, 2'd0, 64'd0, 1'b1, 2'd3);
            tick();
        end

        // Interleaved ch0 writes / ch1 reads, then reset mid-stream.
        for (int k = 0; k < 60; k++) begin
            drive(1'b1, 2'd1, 64'(32'h1100_0000 + k), 1'b0, 2'd0);
            tick();
        end
        for (int k = 0; k < 300; k++) begin
            drive(1'b1, 2'd0, {$urandom, $urandom}, 1'b1, 2'd1);
            tick();
        end
        check("ovf0_interleave", 64'(ovf[0]), 64'd1);
        check("udf1_interleave", 64'(udf[1]), 64'd1);
        drive(1'b1, 2'd0, 64'h77, 1'b1, 2'd0);
        reset = 1'b1;
        tick();
        check("midreset_usedw", 64'(usedw), 64'd0);
        check("midreset_empty", 64'(empty), 64'hF);
        reset = 1'b0;

        // Random traffic against the scoreboard.
        for (int i = 0; i < 1500; i++) begin
            wren    = ($urandom_range(0, 9) < 7);
            wrch    = 2'($urandom_range(0, 3));
            datain  = {$urandom, $urandom};
            rden    = ($urandom_range(0, 9) < 5);
            rdch    = 2'($urandom_range(0, 3));
            err_clr = ($urandom_range(0, 49) == 0);
            hwm_clr = ($urandom_range(0, 49) == 0);
            reset   = ($urandom_range(0, 499) == 0);
            tick();
        end
        drive(1'b0, 2'd0, 64'd0, 1'b0, 2'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
